// File: rtl/mem_align_bridge_pkg.sv
// Shared types for the memory alignment bridge.
//   state_t    : bridge FSM states
//   mem_size_t : access size taken from funct3[1:0]
//   mem_err_t  : completion error code returned with mem_resp
package mem_bridge_types;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      ERR_NONE       = 2'd0,
      ERR_MISALIGNED = 2'd1,
      ERR_ILLEGAL    = 2'd2,
      ERR_TIMEOUT    = 2'd3
   } mem_err_t;

   // funct3[1:0] encoding with no legal RV32I size
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

endpackage

// File: rtl/mem_align_bridge_lane.sv
// Combinational byte-lane alignment for RV32I loads and stores.
// Ports:
//   size          : access size (funct3[1:0])
//   off           : byte offset within the word (addr[1:0])
//   wdata         : right-justified store data
//   rdata         : raw physical read word
//   be            : store byte enables (unused lanes zero)
//   wdata_shifted : store data moved into its lanes
//   rdata_aligned : load data right-justified and zero-masked to size
//   misaligned    : half on odd offset or word on non-zero offset
module mem_lane_align
   import mem_bridge_types::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_shifted,
   output logic [31:0] rdata_aligned,
   output logic        misaligned
);

   logic [4:0]  shamt;
   logic [31:0] rdata_shifted;

   always_comb begin
      shamt         = {off, 3'b000};
      wdata_shifted = wdata << shamt;
      rdata_shifted = rdata >> shamt;
      be            = 4'b0000;
      rdata_aligned = 32'h0;
      misaligned    = 1'b0;
      case (size)
         SZ_BYTE: begin
            be            = 4'b0001 << off;
            rdata_aligned = {24'h0, rdata_shifted[7:0]};
         end
         SZ_HALF: begin
            be            = 4'b0011 << off;
            rdata_aligned = {16'h0, rdata_shifted[15:0]};
            misaligned    = off[0];
         end
         SZ_WORD: begin
            be            = 4'b1111;
            rdata_aligned = rdata_shifted;
            misaligned    = (off != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_align_bridge.sv
// Bridge between the CPU byte-addressed memory port and a word-addressed
// physical memory with a variable-latency response. Aligns store data and
// byte enables, right-justifies load data, rejects illegal/misaligned
// requests and times out a physical access that never responds.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   mem_read/mem_write            : CPU request strobes, held until mem_resp
//   mem_address/wdata/funct3      : CPU byte address, store data, size code
//   mem_resp/mem_rdata/mem_error  : one-cycle completion, load data, error code
//   pmem_read/pmem_write          : physical strobes
//   pmem_address/wdata/byte_enable: physical word address, lane data, enables
//   pmem_resp/pmem_rdata          : physical completion and read word
//
// state | meaning
// IDLE  | waiting for a CPU strobe; checks and launches the access
// WAIT  | physical access outstanding; counts cycles toward timeout
// DONE  | mem_resp high for this single cycle
module mem_align_bridge
   import mem_bridge_types::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_wdata,
   input  logic [2:0]  mem_funct3,
   output logic        mem_resp,
   output logic [31:0] mem_rdata,
   output logic [1:0]  mem_error,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic [31:0] pmem_address,
   output logic [31:0] pmem_wdata,
   output logic [3:0]  pmem_byte_enable,
   input  logic        pmem_resp,
   input  logic [31:0] pmem_rdata
);

   localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

   state_t      state, state_n;
   logic [15:0] cnt, cnt_n;
   logic        is_read, is_read_n;
   logic [1:0]  size_q, size_n;
   logic [1:0]  off_q, off_n;

   logic        mem_resp_n;
   logic [31:0] mem_rdata_n;
   mem_err_t    mem_error_n;
   logic        pmem_read_n;
   logic        pmem_write_n;
   logic [31:0] pmem_address_n;
   logic [31:0] pmem_wdata_n;
   logic [3:0]  pmem_byte_enable_n;

   logic [1:0]  lane_size;
   logic [1:0]  lane_off;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] lane_rdata;
   logic        lane_misaligned;

   // In IDLE the aligner sees the live request; in WAIT it sees the
   // latched size/offset so the returning read word can be aligned.
   assign lane_size = (state == IDLE) ? mem_funct3[1:0]  : size_q;
   assign lane_off  = (state == IDLE) ? mem_address[1:0] : off_q;

   mem_lane_align u_lane (
      .size          (lane_size),
      .off           (lane_off),
      .wdata         (mem_wdata),
      .rdata         (pmem_rdata),
      .be            (lane_be),
      .wdata_shifted (lane_wdata),
      .rdata_aligned (lane_rdata),
      .misaligned    (lane_misaligned)
   );

   always_comb begin
      state_n            = state;
      cnt_n              = cnt;
      is_read_n          = is_read;
      size_n             = size_q;
      off_n              = off_q;
      mem_resp_n         = 1'b0;
      mem_rdata_n        = 32'h0;
      mem_error_n        = ERR_NONE;
      pmem_read_n        = pmem_read;
      pmem_write_n       = pmem_write;
      pmem_address_n     = pmem_address;
      pmem_wdata_n       = pmem_wdata;
      pmem_byte_enable_n = pmem_byte_enable;

      case (state)
         IDLE: begin
            if (mem_read || mem_write) begin
               is_read_n = mem_read;
               size_n    = mem_funct3[1:0];
               off_n     = mem_address[1:0];
               if ((mem_read && mem_write) || (mem_funct3[1:0] == SZ_ILLEGAL)) begin
                  state_n     = DONE;
                  mem_resp_n  = 1'b1;
                  mem_error_n = ERR_ILLEGAL;
               end else if (lane_misaligned) begin
                  state_n     = DONE;
                  mem_resp_n  = 1'b1;
                  mem_error_n = ERR_MISALIGNED;
               end else begin
                  state_n            = WAIT;
                  cnt_n              = 16'd0;
                  pmem_read_n        = mem_read;
                  pmem_write_n       = mem_write;
                  pmem_address_n     = {mem_address[31:2], 2'b00};
                  pmem_wdata_n       = lane_wdata;
                  pmem_byte_enable_n = mem_read ? 4'b1111 : lane_be;
               end
            end
         end
         WAIT: begin
            if (pmem_resp) begin
               state_n      = DONE;
               pmem_read_n  = 1'b0;
               pmem_write_n = 1'b0;
               mem_resp_n   = 1'b1;
               mem_rdata_n  = is_read ? lane_rdata : 32'h0;
            end else if (cnt == LAST_WAIT) begin
               state_n      = DONE;
               pmem_read_n  = 1'b0;
               pmem_write_n = 1'b0;
               mem_resp_n   = 1'b1;
               mem_error_n  = ERR_TIMEOUT;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         cnt              <= 16'd0;
         is_read          <= 1'b0;
         size_q           <= 2'b00;
         off_q            <= 2'b00;
         mem_resp         <= 1'b0;
         mem_rdata        <= 32'h0;
         mem_error        <= 2'b00;
         pmem_read        <= 1'b0;
         pmem_write       <= 1'b0;
         pmem_address     <= 32'h0;
         pmem_wdata       <= 32'h0;
         pmem_byte_enable <= 4'b0000;
      end else begin
         state            <= state_n;
         cnt              <= cnt_n;
         is_read          <= is_read_n;
         size_q           <= size_n;
         off_q            <= off_n;
         mem_resp         <= mem_resp_n;
         mem_rdata        <= mem_rdata_n;
         mem_error        <= mem_error_n;
         pmem_read        <= pmem_read_n;
         pmem_write       <= pmem_write_n;
         pmem_address     <= pmem_address_n;
         pmem_wdata       <= pmem_wdata_n;
         pmem_byte_enable <= pmem_byte_enable_n;
      end
   end

endmodule

// File: tb/tb_mem_align_bridge.sv
module tb_mem_align_bridge;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_read, mem_write;
   logic [31:0] mem_address, mem_wdata;
   logic [2:0]  mem_funct3;
   logic        mem_resp;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_error;
   logic        pmem_read, pmem_write;
   logic [31:0] pmem_address, pmem_wdata;
   logic [3:0]  pmem_byte_enable;
   logic        pmem_resp;
   logic [31:0] pmem_rdata;

   mem_align_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .clk              (clk),
      .rst              (rst),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .mem_address      (mem_address),
      .mem_wdata        (mem_wdata),
      .mem_funct3       (mem_funct3),
      .mem_resp         (mem_resp),
      .mem_rdata        (mem_rdata),
      .mem_error        (mem_error),
      .pmem_read        (pmem_read),
      .pmem_write       (pmem_write),
      .pmem_address     (pmem_address),
      .pmem_wdata       (pmem_wdata),
      .pmem_byte_enable (pmem_byte_enable),
      .pmem_resp        (pmem_resp),
      .pmem_rdata       (pmem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  err;
      int          at;
   } exp_t;

   exp_t exp_q[$];

   // phys: what the physical memory really holds (written via DUT lanes)
   // refb: byte-level reference memory updated from the CPU-side view
   logic [31:0] phys [int];
   logic [7:0]  refb [int];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, expv, cyc);
      end
   endtask

   function automatic logic [31:0] phys_get(input int idx);
      return phys.exists(idx) ? phys[idx] : 32'h0;
   endfunction

   function automatic logic [7:0] ref_get(input int a);
      return refb.exists(a) ? refb[a] : 8'h0;
   endfunction

   task automatic set_word(input logic [31:0] a, input logic [31:0] v);
      phys[int'(a >> 2)] = v;
      for (int i = 0; i < 4; i++) refb[int'({a[31:2], 2'b00}) + i] = v[8*i +: 8];
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      mem_read = 1'b0;
      mem_write = 1'b0;
      pmem_resp = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] wd,
                         input int delay, input bit noresp);
      exp_t        e;
      int          o, nbytes, err, lat, strobes, exp_strobes, idx;
      logic [3:0]  be_exp;
      logic [31:0] w_exp, w_mask, merged;
      bit          got;
      o = int'(addr[1:0]);
      nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      if ((rd && wr) || f3[1:0] == 2'b11) err = 2;
      else if ((o % nbytes) != 0)          err = 1;
      else if (noresp)                     err = 3;
      else                                 err = 0;
      be_exp = 4'b0000;
      w_exp  = 32'h0;
      w_mask = 32'h0;
      for (int i = 0; i < nbytes && o + i < 4; i++) begin
         be_exp[o + i]          = 1'b1;
         w_exp[8*(o+i) +: 8]    = wd[8*i +: 8];
         w_mask[8*(o+i) +: 8]   = 8'hFF;
      end
      e.rdata = 32'h0;
      if (err == 0 && rd)
         for (int i = 0; i < nbytes; i++) e.rdata[8*i +: 8] = ref_get(int'(addr) + i);
      if (err == 0 && wr)
         for (int i = 0; i < nbytes; i++) refb[int'(addr) + i] = wd[8*i +: 8];
      lat = (err == 1 || err == 2) ? 1 : (err == 3) ? TO + 1 : delay + 2;
      exp_strobes = (err == 1 || err == 2) ? 0 : (err == 3) ? TO : delay + 1;
      idx = int'(addr >> 2);

      @(negedge clk);
      mem_read    = rd;
      mem_write   = wr;
      mem_address = addr;
      mem_funct3  = f3;
      mem_wdata   = wd;
      e.err = 2'(err);
      e.at  = cyc + lat;
      exp_q.push_back(e);
      strobes = 0;
      got = 1'b0;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(negedge clk);
         pmem_resp  = 1'b0;
         pmem_rdata = $urandom;
         if (mem_resp) begin
            got = 1'b1;
            mem_read = 1'b0;
            mem_write = 1'b0;
         end else if (pmem_read || pmem_write) begin
            strobes++;
            if (err == 0 || err == 3) begin
               chk("strobe_kind", {30'h0, pmem_read, pmem_write}, {30'h0, rd, wr});
               chk("pmem_address", pmem_address, {addr[31:2], 2'b00});
               chk("byte_enable", {28'h0, pmem_byte_enable}, {28'h0, rd ? 4'b1111 : be_exp});
               if (wr) chk("pmem_wdata", pmem_wdata & w_mask, w_exp);
            end
            if (!noresp && strobes == delay + 1) begin
               pmem_resp = 1'b1;
               if (pmem_read) begin
                  pmem_rdata = phys_get(idx);
               end else begin
                  merged = phys_get(idx);
                  for (int j = 0; j < 4; j++)
                     if (pmem_byte_enable[j]) merged[8*j +: 8] = pmem_wdata[8*j +: 8];
                  phys[idx] = merged;
               end
            end
         end
      end
      if (!got) begin
         chk("mem_resp_missing", 32'h0, 32'h1);
         exp_q.delete();
         pulse_reset();
      end else begin
         chk("strobe_cycles", strobes, exp_strobes);
      end
   endtask

   // Monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (mem_resp) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_resp", 32'h1, 32'h0);
               end else begin
                  e = exp_q.pop_front();
                  chk("mem_rdata", mem_rdata, e.rdata);
                  chk("mem_error", {30'h0, mem_error}, {30'h0, e.err});
                  chk("resp_cycle", cyc, e.at);
               end
            end else begin
               chk("idle_clear", {mem_error, mem_rdata[29:0]} | {31'h0, |mem_rdata}, 32'h0);
            end
         end
      end
   end

   initial begin
      logic        rd, wr;
      logic [2:0]  f3;
      int          r;
      mem_read = 1'b0;
      mem_write = 1'b0;
      mem_address = 32'h0;
      mem_wdata = 32'h0;
      mem_funct3 = 3'b000;
      pmem_resp = 1'b0;
      pmem_rdata = 32'h0;
      for (int i = 0; i < 16; i++) set_word(32'h1000 + 32'(4*i), $urandom);

      repeat (2) @(negedge clk);
      chk("rst_mem_resp", {31'h0, mem_resp}, 32'h0);
      chk("rst_mem_rdata", mem_rdata, 32'h0);
      chk("rst_mem_error", {30'h0, mem_error}, 32'h0);
      chk("rst_strobes", {30'h0, pmem_read, pmem_write}, 32'h0);
      chk("rst_pmem_address", pmem_address, 32'h0);
      chk("rst_pmem_wdata", pmem_wdata, 32'h0);
      chk("rst_be", {28'h0, pmem_byte_enable}, 32'h0);
      rst = 1'b0;

      set_word(32'h1004, 32'hDEADBEEF);
      do_txn(1, 0, 32'h0000_1004, 3'b010, 32'h0, 1, 0);
      set_word(32'h1004, 32'h11223344);
      do_txn(1, 0, 32'h0000_1006, 3'b000, 32'h0, 0, 0);
      set_word(32'h1000, 32'h11223344);
      do_txn(1, 0, 32'h0000_1002, 3'b101, 32'h0, 2, 0);
      do_txn(0, 1, 32'h0000_2003, 3'b000, 32'h0000_00AB, 0, 0);
      do_txn(0, 1, 32'h0000_2002, 3'b001, 32'h0000_BEEF, 2, 0);
      do_txn(1, 0, 32'h0000_2000, 3'b010, 32'h0, 0, 0);
      do_txn(0, 1, 32'h0000_3001, 3'b010, 32'h1234_5678, 0, 0);
      do_txn(1, 0, 32'h0000_3003, 3'b001, 32'h0, 0, 0);
      do_txn(1, 1, 32'h0000_1000, 3'b010, 32'h0, 0, 0);
      do_txn(1, 0, 32'h0000_1000, 3'b011, 32'h0, 0, 0);
      do_txn(1, 0, 32'h0000_1008, 3'b010, 32'h0, 0, 1);
      do_txn(1, 0, 32'h0000_1008, 3'b010, 32'h0, 0, 0);
      do_txn(0, 1, 32'h0000_100C, 3'b010, 32'hCAFE_F00D, 3, 0);
      do_txn(1, 0, 32'h0000_100C, 3'b010, 32'h0, 3, 0);

      for (int n = 0; n < 200; n++) begin
         r  = $urandom_range(0, 19);
         rd = 1'($urandom_range(0, 1));
         wr = !rd;
         if (r == 0) begin
            rd = 1'b1;
            wr = 1'b1;
         end
         case ($urandom_range(0, 5))
            0:       f3 = 3'b000;
            1:       f3 = 3'b001;
            2:       f3 = 3'b010;
            3:       f3 = 3'b100;
            4:       f3 = 3'b101;
            default: f3 = (r == 1) ? 3'b011 : 3'b010;
         endcase
         do_txn(rd, wr, 32'h1000 + 32'($urandom_range(0, 63)), f3, $urandom,
                $urandom_range(0, TO - 1), r == 2);
      end

      // reset in the middle of an outstanding read
      @(negedge clk);
      mem_read = 1'b1;
      mem_write = 1'b0;
      mem_address = 32'h0000_1008;
      mem_funct3 = 3'b010;
      @(negedge clk);
      chk("rst_pre_strobe", {31'h0, pmem_read}, 32'h1);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_drop_read", {31'h0, pmem_read}, 32'h0);
      chk("rst_drop_addr", pmem_address, 32'h0);
      chk("rst_drop_be", {28'h0, pmem_byte_enable}, 32'h0);
      chk("rst_drop_resp", {31'h0, mem_resp}, 32'h0);
      mem_read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      pmem_resp = 1'b1;
      pmem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      pmem_resp = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_resp", {31'h0, mem_resp}, 32'h0);
         chk("rst_no_strobe", {30'h0, pmem_read, pmem_write}, 32'h0);
      end
      do_txn(1, 0, 32'h0000_1008, 3'b010, 32'h0, 1, 0);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_align_bridge.md
Name: mem_align_bridge

Overview:
- Sits between the multicycle control/datapath memory port (mem_read/mem_write/mem_address/mem_wdata) and a word-addressed physical memory with a variable-latency resp handshake.
- Performs byte-lane alignment for RV32I loads and stores:
  - stores: shifts write data, generates byte enables
  - loads: right-justifies read data so the datapath's MDR low bits hold the addressed byte/half
- Checks alignment, rejects illegal requests and enforces a response timeout.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before a timeout error; legal range 1..65535.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- mem_read  input  1  CPU load request, held until mem_resp
- mem_write  input  1  CPU store request, held until mem_resp
- mem_address  input  32  byte address
- mem_wdata  input  32  store data, right-justified
- mem_funct3  input  3  load/store funct3; [1:0] gives size 00=byte, 01=half, 10=word, 11=illegal
- mem_resp  output  1  one-cycle completion pulse
- mem_rdata  output  32  right-justified load data, upper bytes zero; valid while mem_resp=1
- mem_error  output  2  err code, valid while mem_resp=1; 0 none, 1 misaligned, 2 illegal, 3 timeout
- pmem_read  output  1  physical read strobe
- pmem_write  output  1  physical write strobe
- pmem_address  output  32  {addr[31:2], 2'b00}
- pmem_wdata  output  32  lane-shifted store data
- pmem_byte_enable  output  4  active lanes
- pmem_resp  input  1  physical completion
- pmem_rdata  input  32  physical read word

Behaviour:
- Reset (async, rst=1): state=IDLE; every output is 0, including mem_rdata, mem_error and pmem_byte_enable; timeout counter=0. Reset mid-transaction drops pmem strobes immediately with no response; a later pmem_resp is ignored.
- All outputs are registered.
- States: IDLE, WAIT, DONE.
- IDLE:
  - Samples mem_read/mem_write and latches address, funct3, wdata. off=addr[1:0].
  - Error checks, in priority order:
    - both strobes high, or size=11 -> err 2
    - half with off[0]=1, or word with off!=0 -> err 1
  - On error: go to DONE, no pmem access.
  - Otherwise go to WAIT and assert pmem_read or pmem_write with address, wdata and enables, counter=0.
  - Neither strobe high: remain in IDLE.
- Lane rules:
  - read: pmem_byte_enable=4'b1111
  - store byte: be=4'b0001<<off
  - store half: be=4'b0011<<off
  - store word: be=4'b1111
  - pmem_wdata=mem_wdata<<(8*off) (low-order bits fill the enabled lanes; other lanes don't-care, driven as shifted value).
- WAIT:
  - pmem strobes and address/data/enables are held stable.
  - On pmem_resp=1:
    - read: mem_rdata <= pmem_rdata>>(8*off), masked to size (byte keeps [7:0], half keeps [15:0], word keeps all); upper bits zero. Sign extension is done downstream.
    - Drop strobes and go to DONE with err 0.
  - Otherwise counter++. When counter==TIMEOUT_CYCLES-1 and still no resp: drop strobes, go to DONE with err 3, mem_rdata=0.
- DONE: mem_resp=1 for exactly one cycle, then go to IDLE; mem_resp, mem_rdata and mem_error clear to 0 the following cycle.
- pmem_resp is ignored in IDLE/DONE.
- Latency: request seen in cycle 0; pmem strobe high in cycle 1; pmem_resp in cycle k>=1 gives mem_resp in cycle k+1. Zero-wait memory gives mem_resp in cycle 2. Error paths give mem_resp in cycle 1.
- The requester must deassert strobes in the cycle after mem_resp. A request still high in IDLE is treated as new.

Decomposition:
- Package mem_bridge_types:
  - state_t {IDLE, WAIT, DONE}
  - mem_size_t {SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10}
  - mem_err_t {ERR_NONE, ERR_MISALIGNED, ERR_ILLEGAL, ERR_TIMEOUT}
- Sub-module mem_lane_align (combinational): inputs size, off, wdata, rdata; outputs be, shifted wdata, aligned/masked rdata, misaligned flag.
- The FSM, timeout counter and output registers stay in mem_align_bridge.

Test Plan:
- lw @0x0000_1004, pmem_resp 1 cycle after strobe, pmem_rdata=0xDEADBEEF -> pmem_address=0x1004, be=1111, mem_resp in cycle 3 with rdata=0xDEADBEEF, err 0.
- lb @0x1006 (funct3=000), pmem_rdata=0x11223344 -> mem_rdata=0x00000022. lhu @0x1002 -> mem_rdata=0x00001122.
- sb @0x2003, wdata=0x000000AB -> pmem_write=1, pmem_address=0x2000, be=1000, pmem_wdata[31:24]=0xAB. sh @0x2002, wdata=0xBEEF -> be=1100, pmem_wdata[31:16]=0xBEEF.
- sw @0x3001 -> no pmem strobe, mem_resp in cycle 1, err 1. lh @0x3003 -> err 1. mem_read&mem_write both high -> err 2. funct3=011 -> err 2.
- TIMEOUT_CYCLES=4, pmem_resp never asserted -> strobe high for exactly 4 cycles, then mem_resp with err 3, rdata=0. Back-to-back lw immediately after succeeds.
- rst asserted during WAIT -> pmem_read low same cycle, no mem_resp. A pmem_resp arriving after reset is ignored; the next request completes normally.
